// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the control sequencer: IR field layout, opcode
// map, opcode classes and the sequencer state encoding.
package ctrl_seq_pkg;

  // IR field layout
  localparam int OP_MSB  = 31;
  localparam int OPC_W   = 5;
  localparam int FIELD_W = 4;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  // Opcode map and class ranges
  localparam logic [OPC_W-1:0] OP_R3_LO  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_R3_HI  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_IMM_LO = 5'b01100;
  localparam logic [OPC_W-1:0] OP_IMM_HI = 5'b01110;
  localparam logic [OPC_W-1:0] OP_MUL    = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV    = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG    = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT    = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NOP    = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT   = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILL, CLS_R3, CLS_IMM, CLS_MD, CLS_UN, CLS_NOP, CLS_HALT
  } op_class_t;

  // Map an opcode to its execution class; anything unlisted is illegal.
  function automatic op_class_t classify(input logic [OPC_W-1:0] op);
    if (op >= OP_R3_LO && op <= OP_R3_HI)        return CLS_R3;
    else if (op >= OP_IMM_LO && op <= OP_IMM_HI) return CLS_IMM;
    else if (op == OP_MUL || op == OP_DIV)       return CLS_MD;
    else if (op == OP_NEG || op == OP_NOT)       return CLS_UN;
    else if (op == OP_NOP)                       return CLS_NOP;
    else if (op == OP_HALT)                      return CLS_HALT;
    else                                         return CLS_ILL;
  endfunction

endpackage

// File: rtl/onehot_dec4.sv
// 4-bit register field to 16-bit one-hot select.
module onehot_dec4 (
  input  logic [3:0]  field,
  output logic [15:0] onehot
);

  // Single set bit at the position named by the field
  always_comb begin
    onehot        = '0;
    onehot[field] = 1'b1;
  end

endmodule

// File: rtl/ctrl_seq_unit.sv
// Hard-wired fetch/decode/execute sequencer for the single-bus datapath.
// Strobes are decoded from the registered state; in T3 the live IR is
// decoded, and from T4 on the decode captured at the end of T3 is used.
module ctrl_seq_unit
  import ctrl_seq_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [31:0]     ir,
  output logic [NREG-1:0] R_rd,
  output logic [NREG-1:0] R_wrt,
  output logic            HI_out,
  output logic            LO_out,
  output logic            Zhi_out,
  output logic            Zlo_out,
  output logic            PC_out,
  output logic            MDR_out,
  output logic            C_out,
  output logic            MAR_rd,
  output logic            PC_rd,
  output logic            MDR_rd,
  output logic            IR_rd,
  output logic            Y_rd,
  output logic            Zlo_rd,
  output logic            HI_rd,
  output logic            LO_rd,
  output logic            IncPC,
  output logic            Read,
  output logic [OPW-1:0]  op_sel,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  state_t              state, state_nxt;
  op_class_t           cls_q, cls_cur;
  logic [OPW-1:0]      op_q, op_cur;
  logic [FIELD_W-1:0]  ra_q, rb_q, rc_q, ra_cur, rb_cur, rc_cur;
  logic [NREG-1:0]     ra_oh, rb_oh, rc_oh;
  logic                in_t3;
  logic                unused_ir;

  assign in_t3     = (state == S_T3);
  assign unused_ir = ^ir[RC_LSB-1:0];

  // Live IR decode during T3, held decode afterwards
  always_comb begin
    if (in_t3) begin
      op_cur  = ir[OP_MSB -: OPW];
      cls_cur = classify(ir[OP_MSB -: OPC_W]);
      ra_cur  = ir[RA_LSB +: FIELD_W];
      rb_cur  = ir[RB_LSB +: FIELD_W];
      rc_cur  = ir[RC_LSB +: FIELD_W];
    end else begin
      op_cur  = op_q;
      cls_cur = cls_q;
      ra_cur  = ra_q;
      rb_cur  = rb_q;
      rc_cur  = rc_q;
    end
  end

  onehot_dec4 u_dec_ra (.field(ra_cur), .onehot(ra_oh));
  onehot_dec4 u_dec_rb (.field(rb_cur), .onehot(rb_oh));
  onehot_dec4 u_dec_rc (.field(rc_cur), .onehot(rc_oh));

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Capture the T3 decode for the remaining execute states
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q  <= '0;
      cls_q <= CLS_ILL;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else if (in_t3) begin
      op_q  <= op_cur;
      cls_q <= cls_cur;
      ra_q  <= ra_cur;
      rb_q  <= rb_cur;
      rc_q  <= rc_cur;
    end
  end

  // Next-state: fetch is common, execute length depends on the class
  always_comb begin
    state_t done_nxt;
    done_nxt  = run ? S_T0 : S_IDLE;
    state_nxt = state;
    unique case (state)
      S_IDLE:   state_nxt = run ? S_T0 : S_IDLE;
      S_T0:     state_nxt = S_T1;
      S_T1:     state_nxt = S_T2;
      S_T2:     state_nxt = S_T3;
      S_T3: begin
        case (cls_cur)
          CLS_HALT:         state_nxt = S_HALTED;
          CLS_NOP, CLS_ILL: state_nxt = done_nxt;
          default:          state_nxt = S_T4;
        endcase
      end
      S_T4:     state_nxt = (cls_cur == CLS_UN) ? done_nxt : S_T5;
      S_T5:     state_nxt = (cls_cur == CLS_MD) ? S_T6 : done_nxt;
      S_T6:     state_nxt = done_nxt;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore strobe decode from the current state and class
  always_comb begin
    R_rd    = '0;
    R_wrt   = '0;
    HI_out  = 1'b0;
    LO_out  = 1'b0;
    Zhi_out = 1'b0;
    Zlo_out = 1'b0;
    PC_out  = 1'b0;
    MDR_out = 1'b0;
    C_out   = 1'b0;
    MAR_rd  = 1'b0;
    PC_rd   = 1'b0;
    MDR_rd  = 1'b0;
    IR_rd   = 1'b0;
    Y_rd    = 1'b0;
    Zlo_rd  = 1'b0;
    HI_rd   = 1'b0;
    LO_rd   = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    op_sel  = '0;
    illegal = 1'b0;
    busy    = (state != S_IDLE) && (state != S_HALTED);
    halted  = (state == S_HALTED);
    case (state)
      S_T0: begin
        PC_out = 1'b1;
        MAR_rd = 1'b1;
        IncPC  = 1'b1;
      end
      S_T1: begin
        Read   = 1'b1;
        MDR_rd = 1'b1;
      end
      S_T2: begin
        MDR_out = 1'b1;
        IR_rd   = 1'b1;
      end
      S_T3: begin
        case (cls_cur)
          CLS_R3, CLS_IMM, CLS_MD: begin
            R_wrt = rb_oh;
            Y_rd  = 1'b1;
          end
          CLS_UN: begin
            R_wrt  = rb_oh;
            op_sel = op_cur;
            Zlo_rd = 1'b1;
          end
          CLS_ILL: illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (cls_cur)
          CLS_R3, CLS_MD: begin
            R_wrt  = rc_oh;
            op_sel = op_cur;
            Zlo_rd = 1'b1;
          end
          CLS_IMM: begin
            C_out  = 1'b1;
            op_sel = op_cur;
            Zlo_rd = 1'b1;
          end
          CLS_UN: begin
            Zlo_out = 1'b1;
            R_rd    = ra_oh;
          end
          default: ;
        endcase
      end
      S_T5: begin
        Zlo_out = 1'b1;
        if (cls_cur == CLS_MD) LO_rd = 1'b1;
        else                   R_rd  = ra_oh;
      end
      S_T6: begin
        Zhi_out = 1'b1;
        HI_rd   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Scoreboard bench for ctrl_seq_unit: expected strobe vectors are queued
// as each cycle is driven and compared on the following falling edge.
module tb_ctrl_seq_unit;

  typedef struct packed {
    logic [15:0] r_rd;
    logic [15:0] r_wrt;
    logic [6:0]  bus;   // {HI,LO,Zhi,Zlo,PC,MDR,C}
    logic [7:0]  ld;    // {MAR,PC,MDR,IR,Y,Zlo,HI,LO}
    logic        inc_pc;
    logic        read;
    logic [4:0]  op_sel;
    logic        busy;
    logic        halted;
    logic        illegal;
  } out_t;

  localparam int B_HI = 6, B_LO = 5, B_ZHI = 4, B_ZLO = 3, B_PC = 2, B_MDR = 1, B_C = 0;
  localparam int L_MAR = 7, L_MDR = 5, L_IR = 4, L_Y = 3, L_ZLO = 2, L_HI = 1, L_LO = 0;

  logic        clk = 1'b0;
  logic        clr, run;
  logic [31:0] ir;
  logic [15:0] R_rd, R_wrt;
  logic HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, C_out;
  logic MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, HI_rd, LO_rd;
  logic IncPC, Read, busy, halted, illegal;
  logic [4:0] op_sel;
  out_t obs;

  out_t  exp_q[$];
  string tag_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ctrl_seq_unit #(.OPW(5), .NREG(16)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir),
    .R_rd(R_rd), .R_wrt(R_wrt),
    .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PC_out(PC_out), .MDR_out(MDR_out), .C_out(C_out),
    .MAR_rd(MAR_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd),
    .Y_rd(Y_rd), .Zlo_rd(Zlo_rd), .HI_rd(HI_rd), .LO_rd(LO_rd),
    .IncPC(IncPC), .Read(Read), .op_sel(op_sel),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {R_rd, R_wrt, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, C_out,
                MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, HI_rd, LO_rd,
                IncPC, Read, op_sel, busy, halted, illegal};

  task automatic check_out(input string tag, input out_t got, input out_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Compare each queued expectation against the DUT mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_out(tag_q.pop_front(), obs, exp_q.pop_front());
  end

  // One clock: after the edge, drive ir/run and queue this cycle's expectation
  task automatic cycle(input out_t e, input logic [31:0] ir_v, input logic run_v, input string tag);
    @(posedge clk);
    #1;
    ir  = ir_v;
    run = run_v;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Drive one instruction from T0; run goes low from cycle drop_at on,
  // and at cycle abort_at clr is pulled low mid-cycle instead.
  task automatic do_instr(input logic [31:0] instr, input int drop_at, input int abort_at,
                          input string name);
    out_t        seq[$];
    out_t        e;
    logic [4:0]  op;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    op    = instr[31:27];
    ra_oh = 16'h0001 << instr[26:23];
    rb_oh = 16'h0001 << instr[22:19];
    rc_oh = 16'h0001 << instr[18:15];
    e = '0; e.bus[B_PC] = 1; e.ld[L_MAR] = 1; e.inc_pc = 1; e.busy = 1; seq.push_back(e);
    e = '0; e.read = 1; e.ld[L_MDR] = 1; e.busy = 1; seq.push_back(e);
    e = '0; e.bus[B_MDR] = 1; e.ld[L_IR] = 1; e.busy = 1; seq.push_back(e);
    if ((op >= 5'd3 && op <= 5'd11) || (op >= 5'd12 && op <= 5'd14)) begin
      e = '0; e.r_wrt = rb_oh; e.ld[L_Y] = 1; e.busy = 1; seq.push_back(e);
      e = '0; e.op_sel = op; e.ld[L_ZLO] = 1; e.busy = 1;
      if (op <= 5'd11) e.r_wrt = rc_oh;
      else             e.bus[B_C] = 1;
      seq.push_back(e);
      e = '0; e.bus[B_ZLO] = 1; e.r_rd = ra_oh; e.busy = 1; seq.push_back(e);
    end else if (op == 5'd15 || op == 5'd16) begin
      e = '0; e.r_wrt = rb_oh; e.ld[L_Y] = 1; e.busy = 1; seq.push_back(e);
      e = '0; e.r_wrt = rc_oh; e.op_sel = op; e.ld[L_ZLO] = 1; e.busy = 1; seq.push_back(e);
      e = '0; e.bus[B_ZLO] = 1; e.ld[L_LO] = 1; e.busy = 1; seq.push_back(e);
      e = '0; e.bus[B_ZHI] = 1; e.ld[L_HI] = 1; e.busy = 1; seq.push_back(e);
    end else if (op == 5'd17 || op == 5'd18) begin
      e = '0; e.r_wrt = rb_oh; e.op_sel = op; e.ld[L_ZLO] = 1; e.busy = 1; seq.push_back(e);
      e = '0; e.bus[B_ZLO] = 1; e.r_rd = ra_oh; e.busy = 1; seq.push_back(e);
    end else begin
      e = '0; e.busy = 1;
      if (op != 5'd26 && op != 5'd27) e.illegal = 1;
      seq.push_back(e);
    end
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check_out($sformatf("%s_abort_T%0d", name, i), obs, '0);
        return;
      end
      cycle(seq[i], (i == 3) ? instr : $urandom(), (i >= drop_at) ? 1'b0 : 1'b1,
            $sformatf("%s_T%0d", name, i));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t h;
    clr = 1'b0;
    run = 1'b0;
    ir  = '0;
    #3;
    check_out("reset_async", obs, '0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check_out("reset_hold", obs, '0);
    run = 1'b1;
    #1;
    clr = 1'b1;

    do_instr(32'h2A2B8000, 99, 99, "r3_and");
    do_instr(32'h6108000F, 99, 99, "addi");
    do_instr(32'h781B8000, 99, 99, "mul");
    do_instr({5'b10001, 4'd9, 4'd6, 4'd0, 15'h0}, 99, 99, "neg");
    do_instr(32'hF8000000, 99, 99, "ill_1f");
    do_instr({5'b11010, 4'd5, 4'd5, 4'd5, 15'h1234}, 99, 99, "nop");
    do_instr({5'b00010, 4'd1, 4'd2, 4'd3, 15'h0}, 99, 99, "ill_02");
    do_instr({5'b10011, 4'd1, 4'd2, 4'd3, 15'h0}, 99, 99, "ill_13");
    do_instr({5'b00011, 4'd15, 4'd0, 4'd8, 15'h0}, 99, 99, "r3_lo");
    do_instr({5'b01011, 4'd0, 4'd15, 4'd1, 15'h0}, 99, 99, "r3_hi");
    do_instr({5'b01110, 4'd11, 4'd12, 4'd13, 15'h7FFF}, 99, 99, "imm_hi");
    do_instr({5'b10000, 4'd2, 4'd14, 4'd6, 15'h0}, 99, 99, "div");
    do_instr({5'b10010, 4'd15, 4'd15, 4'd15, 15'h0}, 99, 99, "not");

    // run dropped in T2: instruction completes, then IDLE
    do_instr({5'b00100, 4'd3, 4'd4, 4'd5, 15'h0}, 2, 99, "drop");
    cycle('0, $urandom(), 1'b0, "drop_idle0");
    cycle('0, $urandom(), 1'b1, "drop_idle1");

    // clr during T4 of an R3 op: nothing from it after release
    do_instr({5'b00101, 4'd6, 4'd7, 4'd8, 15'h0}, 99, 4, "abort");
    run = 1'b0;
    #4;
    clr = 1'b1;
    cycle('0, $urandom(), 1'b0, "abort_idle0");
    cycle('0, $urandom(), 1'b0, "abort_idle1");
    cycle('0, $urandom(), 1'b1, "abort_idle2");
    do_instr({5'b00110, 4'd1, 4'd2, 4'd3, 15'h0}, 99, 99, "post_abort");

    // halt: holds with strobes low until clr
    do_instr(32'hD8000000, 99, 99, "halt");
    h = '0;
    h.halted = 1'b1;
    for (int i = 0; i < 20; i++) cycle(h, $urandom(), 1'b1, $sformatf("halted_%0d", i));
    @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    check_out("halt_clr", obs, '0);
    run = 1'b0;
    #3;
    clr = 1'b1;
    cycle('0, $urandom(), 1'b0, "halt_idle0");
    cycle('0, $urandom(), 1'b1, "halt_idle1");
    do_instr({5'b11010, 4'd0, 4'd0, 4'd0, 15'h0}, 99, 99, "restart_nop");

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
